// File: rtl/syn_fifo_ext.sv
// Single-clock FIFO with registered-read or first-word-fall-through output, occupancy
// flags derived from a registered count, and sticky-free overflow/underflow pulses.
module syn_fifo_ext #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = 14,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  is_empty,
  output logic                  is_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   data_avail,
  output logic [ADDR_WIDTH:0]   room_avail,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DepthCnt  = CntW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AfullCnt  = CntW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AemptyCnt = CntW'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] One       = CntW'(1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_WIDTH:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic rd_acc;
  logic wr_ok;
  logic wr_acc;

  assign is_empty     = (count_q == '0);
  assign is_full      = (count_q == DepthCnt);
  assign almost_full  = (count_q >= AfullCnt);
  assign almost_empty = (count_q <= AemptyCnt);
  assign data_avail   = count_q;
  assign room_avail   = DepthCnt - count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_acc = r_en && !is_empty && !flush;
  assign wr_ok  = w_en && (!is_full || (r_en && !is_empty));
  assign wr_acc = wr_ok && !flush;

  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      overflow_d  = w_en && !wr_ok;
      underflow_d = r_en && is_empty;
      if (wr_acc) w_ptr_d = w_ptr_q + One;
      if (rd_acc) r_ptr_d = r_ptr_q + One;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + One;
        2'b01:   count_d = count_q - One;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[w_ptr_q[ADDR_WIDTH-1:0]] <= w_data;
  end

  if (FWFT == 0) begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_valid_q, r_valid_d;

    always_comb begin
      r_data_d  = r_data_q;
      r_valid_d = rd_acc;
      if (rd_acc) r_data_d = mem[r_ptr_q[ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_data_q  <= r_data_d;
        r_valid_q <= r_valid_d;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end else begin : g_fwft
    // Head word is shown combinationally; zero while empty keeps the reset value defined.
    assign r_data  = is_empty ? '0 : mem[r_ptr_q[ADDR_WIDTH-1:0]];
    assign r_valid = !is_empty;
  end

endmodule

// File: tb/tb_syn_fifo_ext.sv
// Scoreboard bench: stimulus pushes expected read words into a queue, a negedge monitor
// pops them whenever r_valid is seen; a second instance covers first-word-fall-through.
module tb_syn_fifo_ext;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       w_en;
  logic [7:0] w_data;
  logic       r_en;
  logic [7:0] r_data;
  logic       r_valid, is_empty, is_full, almost_empty, almost_full;
  logic [4:0] data_avail, room_avail;
  logic       overflow, underflow;

  logic       fw_flush, fw_w_en, fw_r_en;
  logic [7:0] fw_w_data, fw_r_data;
  logic       fw_r_valid, fw_is_empty, fw_is_full, fw_almost_empty, fw_almost_full;
  logic [4:0] fw_data_avail, fw_room_avail;
  logic       fw_overflow, fw_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_q[$];
  logic [7:0] exp_q[$];

  syn_fifo_ext #(.FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .r_valid(r_valid), .is_empty(is_empty), .is_full(is_full),
    .almost_empty(almost_empty), .almost_full(almost_full), .data_avail(data_avail),
    .room_avail(room_avail), .overflow(overflow), .underflow(underflow)
  );

  syn_fifo_ext #(.FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .flush(fw_flush), .w_en(fw_w_en), .w_data(fw_w_data),
    .r_en(fw_r_en), .r_data(fw_r_data), .r_valid(fw_r_valid), .is_empty(fw_is_empty),
    .is_full(fw_is_full), .almost_empty(fw_almost_empty), .almost_full(fw_almost_full),
    .data_avail(fw_data_avail), .room_avail(fw_room_avail), .overflow(fw_overflow),
    .underflow(fw_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL r_valid_spurious: got r_valid=1 r_data=%0h, expected r_valid=0 (t=%0t)",
                 r_data, $time);
      end else begin
        chk("r_data", {24'd0, r_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_status(input logic exp_ovf, input logic exp_udf);
    int sz;
    sz = ref_q.size();
    chk("data_avail", {27'd0, data_avail}, sz);
    chk("room_avail", {27'd0, room_avail}, 16 - sz);
    chk("is_empty", {31'd0, is_empty}, {31'd0, sz == 0});
    chk("is_full", {31'd0, is_full}, {31'd0, sz == 16});
    chk("almost_full", {31'd0, almost_full}, {31'd0, sz >= 14});
    chk("almost_empty", {31'd0, almost_empty}, {31'd0, sz <= 2});
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("underflow", {31'd0, underflow}, {31'd0, exp_udf});
  endtask

  task automatic step(input logic w, input logic [7:0] wd, input logic r);
    logic rd_ok, wr_ok;
    int   sz;
    sz    = ref_q.size();
    rd_ok = r && (sz > 0);
    wr_ok = w && ((sz < 16) || rd_ok);
    w_en   = w;
    w_data = wd;
    r_en   = r;
    if (rd_ok) exp_q.push_back(ref_q.pop_front());
    if (wr_ok) ref_q.push_back(wd);
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    check_status(w && !wr_ok, r && !rd_ok);
  endtask

  task automatic do_reset(input logic w, input logic r);
    rst    = 1'b1;
    w_en   = w;
    w_data = 8'hEE;
    r_en   = r;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    w_en = 1'b0;
    r_en = 1'b0;
    ref_q.delete();
    exp_q.delete();
    check_status(1'b0, 1'b0);
    chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_r_data", {24'd0, r_data}, 32'd0);
  endtask

  task automatic do_flush(input logic w, input logic [7:0] wd);
    flush  = 1'b1;
    w_en   = w;
    w_data = wd;
    @(posedge clk);
    #1;
    flush = 1'b0;
    w_en  = 1'b0;
    ref_q.delete();
    check_status(1'b0, 1'b0);
    chk("flush_r_valid", {31'd0, r_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; w_en = 1'b0; w_data = '0; r_en = 1'b0;
    fw_flush = 1'b0; fw_w_en = 1'b0; fw_w_data = '0; fw_r_en = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);
    chk("fw_rst_r_valid", {31'd0, fw_r_valid}, 32'd0);
    chk("fw_rst_is_empty", {31'd0, fw_is_empty}, 32'd1);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
    // Drain in order, then one rejected read.
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Write and read together on an empty FIFO: only the write lands.
    step(1'b1, 8'h33, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Full FIFO streaming across the pointer wrap.
    for (int i = 0; i < 16; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'h80 + 8'(i), 1'b1);

    // Drain to 9 words, flush with a concurrent write, confirm that write vanished.
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("pre_flush_count", {27'd0, data_avail}, 32'd9);
    do_flush(1'b1, 8'hCC);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Reset in the middle of traffic.
    for (int i = 0; i < 6; i++) step(1'b1, 8'h10 + 8'(i), i[0]);
    do_reset(1'b1, 1'b1);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // First-word-fall-through instance.
    fw_w_en   = 1'b1;
    fw_w_data = 8'hA5;
    @(posedge clk);
    #1;
    fw_w_en = 1'b0;
    chk("fw_r_valid_after_write", {31'd0, fw_r_valid}, 32'd1);
    chk("fw_r_data_after_write", {24'd0, fw_r_data}, 32'hA5);
    chk("fw_is_empty_after_write", {31'd0, fw_is_empty}, 32'd0);
    fw_r_en = 1'b1;
    @(posedge clk);
    #1;
    fw_r_en = 1'b0;
    chk("fw_is_empty_after_pop", {31'd0, fw_is_empty}, 32'd1);
    chk("fw_r_valid_after_pop", {31'd0, fw_r_valid}, 32'd0);
    chk("fw_underflow_after_pop", {31'd0, fw_underflow}, 32'd0);

    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_fifo_ext.md
SYN_FIFO_EXT -- requirements
Module: syn_fifo_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, pointer index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entry count, equal to 2**ADDR_WIDTH.
REQ-004 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-005 SHALL have parameter AFULL_THRESH, default 14, almost-full level, range 1..FIFO_DEPTH.
REQ-006 SHALL have parameter AEMPTY_THRESH, default 2, almost-empty level, range 0..FIFO_DEPTH-1.
REQ-007 SHALL have ports: clk in 1, single clock, all logic on rising edge; rst in 1, synchronous active-high reset.
REQ-008 SHALL have ports: flush in 1, synchronous clear; w_en in 1; w_data in DATA_WIDTH; r_en in 1.
REQ-009 SHALL have ports: r_data out DATA_WIDTH; r_valid out 1; is_empty out 1; is_full out 1; almost_empty out 1; almost_full out 1.
REQ-010 SHALL have ports: data_avail out ADDR_WIDTH+1, stored word count; room_avail out ADDR_WIDTH+1, free entries; overflow out 1; underflow out 1.
REQ-011 SHALL contain its own FIFO_DEPTH x DATA_WIDTH storage array, with no external RAM instance.

Function
REQ-012 SHALL keep write and read pointers of ADDR_WIDTH+1 bits plus a count register of ADDR_WIDTH+1 bits.
REQ-013 SHALL accept a write when w_en && (!is_full || read accepted same cycle); the word is stored at w_ptr and w_ptr increments modulo 2**(ADDR_WIDTH+1).
REQ-014 SHALL accept a read when r_en && !is_empty; r_ptr increments, with the same modulo wrap.
REQ-015 SHALL update count by +1 on write only, -1 on read only, and hold it when both or neither are accepted.
REQ-016 SHALL derive all flags from the registered count: data_avail=count; room_avail=FIFO_DEPTH-count; is_empty=(count==0); is_full=(count==FIFO_DEPTH); almost_full=(count>=AFULL_THRESH); almost_empty=(count<=AEMPTY_THRESH). All status outputs change on the same edge as the pointers.
REQ-017 In FWFT=0, SHALL register r_data <= mem[r_ptr] on an accepted read; r_valid SHALL be a 1-cycle pulse in the cycle after an accepted read; r_data SHALL hold otherwise.
REQ-018 In FWFT=1, r_data SHALL present mem[r_ptr] whenever !is_empty, and r_valid SHALL equal !is_empty; r_en pops the head word.
REQ-019 In FWFT=1, a word written into an empty FIFO at edge N SHALL appear on r_data with r_valid=1 after edge N (one-cycle write-to-read latency).
REQ-020 Simultaneous write and read when empty: write accepted, read rejected, underflow pulses.
REQ-021 Simultaneous write and read when full: both accepted, count stays FIFO_DEPTH, is_full stays 1.
REQ-022 overflow SHALL be a 1-cycle registered pulse for each rejected write (w_en while full with no accepted read); the FIFO contents SHALL be unchanged.
REQ-023 underflow SHALL be a 1-cycle registered pulse for each rejected read (r_en while empty); the pointers SHALL be unchanged.
REQ-024 flush SHALL clear pointers and count, force r_valid=0 and clear overflow/underflow on the next edge; flush SHALL take priority over a same-cycle w_en/r_en, and those requests SHALL be discarded.
REQ-025 Pointer wrap SHALL be seamless: full vs empty is distinguished by the count, and no entry is lost or duplicated across the wrap.

Reset
REQ-026 rst SHALL take priority over flush and all requests.
REQ-027 On rst, SHALL set: w_ptr=0, r_ptr=0, count=0, is_empty=1, is_full=0, almost_empty=1, almost_full=0, data_avail=0, room_avail=FIFO_DEPTH, r_valid=0, overflow=0, underflow=0, r_data=0.
REQ-028 Reset asserted mid-traffic SHALL discard all stored words; the first write after rst deasserts SHALL be the first word read.
REQ-029 Storage array contents SHALL NOT require reset.

Verification
REQ-030 Reset, then 16 writes of 0x00..0x0F (defaults) -> is_full=1, almost_full=1 from the 14th write, room_avail=0; a 17th write -> overflow pulse, contents unchanged.
REQ-031 FWFT=0: read 16 words -> r_data 0x00..0x0F, each valid one cycle after r_en, with r_valid pulses; after the last read is_empty=1; an extra r_en -> underflow pulse.
REQ-032 FWFT=1: write 0xA5 into an empty FIFO -> next cycle r_valid=1, r_data=0xA5 with no r_en; r_en -> is_empty=1 after the edge.
REQ-033 Full FIFO with w_en and r_en held for 40 cycles across pointer wrap -> count stays 16, read sequence is strictly in order, no overflow.
REQ-034 flush with w_en=1 at count=9 -> count=0, is_empty=1 next cycle, written word dropped; rst asserted during burst traffic -> all outputs at REQ-027 values.
